// File: rtl/uart_rx_param_if.sv
// Receive-side handshake bundle for uart_rx_param: the delivered word, its
// status flags and the consumer's ready.
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun_err;

  modport master (
    output rx_data, rx_valid, parity_err, frame_err, overrun_err,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, parity_err, frame_err, overrun_err,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-FF rxd synchroniser, start-edge detect,
// internal bit timing, optional parity, 1 or 2 stop bits, and a held
// valid/ready output register with parity/framing/overrun flags.
//
// state   | meaning
// IDLE    | waiting for a falling edge on the synchronised line
// START   | timing to the centre of the start bit to reject glitches
// DATA    | sampling data bits at bit centres, LSB first
// PARITY  | sampling the parity bit and checking it
// STOP    | sampling stop bits; any low sample marks a framing error
// DELIVER | one cycle to hand the frame to the output register
module uart_rx_param #(
  parameter int DATA_BITS   = 8,
  parameter int CLK_DIV     = 434,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx_en,
  input  logic            rxd,
  output logic            busy,
  uart_rx_param_if.master rx_if
);

  localparam int CW = $clog2(CLK_DIV);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DELIVER} state_t;

  state_t               state;
  logic                 rxd_m, rxd_s, rxd_s_q;
  logic [CW-1:0]        baud_cnt;
  logic [3:0]           bit_idx;
  logic [DATA_BITS-1:0] data_sr;
  logic                 p_err, f_err;
  logic                 tick, mid, fall, handshake, deliver;

  assign tick      = (baud_cnt == CW'(CLK_DIV - 1));
  assign mid       = (baud_cnt == CW'(CLK_DIV / 2 - 1));
  assign fall      = rxd_s_q & ~rxd_s;
  assign handshake = rx_if.rx_valid & rx_if.rx_ready;
  assign deliver   = (state == DELIVER) & rx_en;
  assign busy      = (state != IDLE);

  // Synchronise the asynchronous line and keep one delayed copy for edge detect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxd_m   <= 1'b1;
      rxd_s   <= 1'b1;
      rxd_s_q <= 1'b1;
    end else begin
      rxd_m   <= rxd;
      rxd_s   <= rxd_m;
      rxd_s_q <= rxd_s;
    end
  end

  // Frame sequencer: bit timing, sampling, parity and stop checks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      data_sr  <= '0;
      p_err    <= 1'b0;
      f_err    <= 1'b0;
    end else if (!rx_en) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
    end else begin
      baud_cnt <= tick ? '0 : baud_cnt + 1'b1;
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          bit_idx  <= '0;
          p_err    <= 1'b0;
          f_err    <= 1'b0;
          if (fall) state <= START;
        end
        START: begin
          if (mid) begin
            if (rxd_s) begin
              state <= IDLE;
            end else begin
              // restart the bit timer so later ticks land on bit centres
              baud_cnt <= '0;
              state    <= DATA;
            end
          end
        end
        DATA: begin
          if (tick) begin
            data_sr <= {rxd_s, data_sr[DATA_BITS-1:1]};
            if (bit_idx == 4'(DATA_BITS - 1)) begin
              bit_idx <= '0;
              state   <= (PARITY_MODE == 0) ? STOP : PARITY;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        PARITY: begin
          if (tick) begin
            p_err <= (PARITY_MODE == 2) ? ~(^data_sr ^ rxd_s) : (^data_sr ^ rxd_s);
            state <= STOP;
          end
        end
        STOP: begin
          if (tick) begin
            if (!rxd_s) f_err <= 1'b1;
            if (bit_idx == 4'(STOP_BITS - 1)) state <= DELIVER;
            else bit_idx <= bit_idx + 1'b1;
          end
        end
        DELIVER: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Output register: load on delivery, flag overrun when the slot is still
  // occupied, and clear everything except the data word on a handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_if.rx_data     <= '0;
      rx_if.rx_valid    <= 1'b0;
      rx_if.parity_err  <= 1'b0;
      rx_if.frame_err   <= 1'b0;
      rx_if.overrun_err <= 1'b0;
    end else if (deliver && (!rx_if.rx_valid || handshake)) begin
      rx_if.rx_data     <= data_sr;
      rx_if.rx_valid    <= 1'b1;
      rx_if.parity_err  <= p_err;
      rx_if.frame_err   <= f_err;
      rx_if.overrun_err <= 1'b0;
    end else if (deliver) begin
      rx_if.overrun_err <= 1'b1;
    end else if (handshake) begin
      rx_if.rx_valid    <= 1'b0;
      rx_if.parity_err  <= 1'b0;
      rx_if.frame_err   <= 1'b0;
      rx_if.overrun_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three configurations (8N1, 8E2, 9O1) driven with
// directed and random frames, checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_rx_param;
  localparam int DIV = 16;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] rx_en = 3'b111;
  logic [2:0] rxd   = 3'b111;
  logic [2:0] busy;

  int n_cmp = 0;
  int n_bad = 0;

  int cfg_nb [3] = '{8, 8, 9};
  int cfg_pm [3] = '{0, 1, 2};
  int cfg_ns [3] = '{1, 2, 1};

  uart_rx_param_if #(.DATA_BITS(8)) if_a ();
  uart_rx_param_if #(.DATA_BITS(8)) if_b ();
  uart_rx_param_if #(.DATA_BITS(9)) if_c ();

  uart_rx_param #(.DATA_BITS(8), .CLK_DIV(DIV), .PARITY_MODE(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .reset(reset), .rx_en(rx_en[0]), .rxd(rxd[0]), .busy(busy[0]), .rx_if(if_a)
  );
  uart_rx_param #(.DATA_BITS(8), .CLK_DIV(DIV), .PARITY_MODE(1), .STOP_BITS(2)) dut_b (
    .clk(clk), .reset(reset), .rx_en(rx_en[1]), .rxd(rxd[1]), .busy(busy[1]), .rx_if(if_b)
  );
  uart_rx_param #(.DATA_BITS(9), .CLK_DIV(DIV), .PARITY_MODE(2), .STOP_BITS(1)) dut_c (
    .clk(clk), .reset(reset), .rx_en(rx_en[2]), .rxd(rxd[2]), .busy(busy[2]), .rx_if(if_c)
  );

  always #5 clk = ~clk;

  // accepted frames as {parity_err, frame_err, data[8:0]}
  logic [10:0] q_a[$], q_b[$], q_c[$];

  always @(negedge clk) begin
    if (if_a.rx_valid && if_a.rx_ready) q_a.push_back({if_a.parity_err, if_a.frame_err, 1'b0, if_a.rx_data});
    if (if_b.rx_valid && if_b.rx_ready) q_b.push_back({if_b.parity_err, if_b.frame_err, 1'b0, if_b.rx_data});
    if (if_c.rx_valid && if_c.rx_ready) q_c.push_back({if_c.parity_err, if_c.frame_err, if_c.rx_data});
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] build_frame(input int inst, input logic [8:0] d, input logic pflip,
                                              input logic [1:0] stop_pat, output int n);
    logic [15:0] bits;
    logic        pbit;
    bits = '1;
    n = 0;
    bits[n] = 1'b0;
    n++;
    for (int i = 0; i < cfg_nb[inst]; i++) begin
      bits[n] = d[i];
      n++;
    end
    if (cfg_pm[inst] != 0) begin
      // the bit that makes the total count of ones even (even mode) or odd (odd mode)
      pbit = (($countones(d) % 2) == 1) ? (cfg_pm[inst] == 1) : (cfg_pm[inst] == 2);
      bits[n] = pbit ^ pflip;
      n++;
    end
    for (int s = 0; s < cfg_ns[inst]; s++) begin
      bits[n] = stop_pat[s];
      n++;
    end
    return bits;
  endfunction

  task automatic drive_bits(input int inst, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      rxd[inst] = bits[i];
      tick_n(DIV);
    end
  endtask

  function automatic int q_size(input int inst);
    case (inst)
      0:       return q_a.size();
      1:       return q_b.size();
      default: return q_c.size();
    endcase
  endfunction

  task automatic expect_frame(input int inst, input string tag, input logic [8:0] edata,
                              input logic eperr, input logic eferr);
    logic [10:0] r;
    int          sz;
    sz = q_size(inst);
    check_val({tag, "_count"}, 32'(sz), 32'd1);
    if (sz > 0) begin
      case (inst)
        0:       r = q_a.pop_front();
        1:       r = q_b.pop_front();
        default: r = q_c.pop_front();
      endcase
      check_val({tag, "_data"},  32'(r[8:0]), 32'(edata));
      check_val({tag, "_perr"},  32'(r[10]),  32'(eperr));
      check_val({tag, "_ferr"},  32'(r[9]),   32'(eferr));
    end
    q_a.delete();
    q_b.delete();
    q_c.delete();
  endtask

  // Reference model: expected word and flags from the frame description alone.
  task automatic run_frame(input int inst, input string tag, input logic [8:0] data,
                           input logic pflip, input logic [1:0] stop_pat);
    logic [15:0] bits;
    logic [8:0]  d;
    logic        eperr, eferr;
    int          n, ones;
    d = data & ((9'h1 << cfg_nb[inst]) - 9'h1);
    bits = build_frame(inst, d, pflip, stop_pat, n);
    eperr = 1'b0;
    if (cfg_pm[inst] != 0) begin
      ones = $countones(d) + int'(bits[cfg_nb[inst] + 1]);
      eperr = (cfg_pm[inst] == 1) ? (ones % 2 == 1) : (ones % 2 == 0);
    end
    eferr = 1'b0;
    for (int s = 0; s < cfg_ns[inst]; s++) if (!stop_pat[s]) eferr = 1'b1;
    drive_bits(inst, bits, n);
    rxd[inst] = 1'b1;
    tick_n(DIV);
    expect_frame(inst, tag, d, eperr, eferr);
  endtask

  function automatic logic valid_of(input int inst);
    case (inst)
      0:       return if_a.rx_valid;
      1:       return if_b.rx_valid;
      default: return if_c.rx_valid;
    endcase
  endfunction

  task automatic abort_case(input int inst, input bit use_reset, input string tag);
    logic [15:0] bits;
    int          n;
    bits = build_frame(inst, 9'h081, 1'b0, 2'b11, n);
    drive_bits(inst, bits, 5);
    rxd[inst] = bits[5];
    tick_n(DIV / 2);
    check_val({tag, "_busy_mid"}, 32'(busy[inst]), 32'd1);
    rxd[inst] = 1'b1;
    if (use_reset) begin
      reset = 1'b1;
      tick_n(2);
      check_val({tag, "_busy_rst"}, 32'(busy[inst]), 32'd0);
      reset = 1'b0;
    end else begin
      rx_en[inst] = 1'b0;
      tick_n(2);
      check_val({tag, "_busy_dis"}, 32'(busy[inst]), 32'd0);
      rx_en[inst] = 1'b1;
    end
    tick_n(DIV);
    check_val({tag, "_no_valid"}, 32'(valid_of(inst)), 32'd0);
    check_val({tag, "_no_frame"}, 32'(q_size(inst)), 32'd0);
    run_frame(inst, {tag, "_next"}, 9'h081, 1'b0, 2'b11);
  endtask

  initial begin
    logic [15:0] bits;
    int          n;
    if_a.rx_ready = 1'b1;
    if_b.rx_ready = 1'b1;
    if_c.rx_ready = 1'b1;
    tick_n(3);
    check_val("rst_busy",    32'(busy),            32'd0);
    check_val("rst_valid",   32'({if_a.rx_valid, if_b.rx_valid, if_c.rx_valid}), 32'd0);
    check_val("rst_data_a",  32'(if_a.rx_data),    32'd0);
    check_val("rst_data_c",  32'(if_c.rx_data),    32'd0);
    check_val("rst_flags_a", 32'({if_a.parity_err, if_a.frame_err, if_a.overrun_err}), 32'd0);
    reset = 1'b0;
    tick_n(2);

    run_frame(0, "8n1_a5", 9'h0A5, 1'b0, 2'b11);
    run_frame(1, "par_bad", 9'h007, 1'b1, 2'b11);
    run_frame(1, "par_ok", 9'h007, 1'b0, 2'b11);
    run_frame(2, "odd_ok", 9'h1C3, 1'b0, 2'b11);

    rxd[0] = 1'b0;
    tick_n(4);
    rxd[0] = 1'b1;
    tick_n(1);
    check_val("glitch_busy_hi", 32'(busy[0]), 32'd1);
    tick_n(DIV);
    check_val("glitch_busy_lo", 32'(busy[0]), 32'd0);
    check_val("glitch_no_frame", 32'(q_size(0)), 32'd0);
    run_frame(0, "after_glitch", 9'h03C, 1'b0, 2'b11);

    if_a.rx_ready = 1'b0;
    bits = build_frame(0, 9'h011, 1'b0, 2'b11, n);
    drive_bits(0, bits, n);
    bits = build_frame(0, 9'h022, 1'b0, 2'b11, n);
    drive_bits(0, bits, n);
    rxd[0] = 1'b1;
    tick_n(DIV);
    @(negedge clk);
    check_val("ovr_valid", 32'(if_a.rx_valid),    32'd1);
    check_val("ovr_data",  32'(if_a.rx_data),     32'h11);
    check_val("ovr_flag",  32'(if_a.overrun_err), 32'd1);
    @(posedge clk);
    #1;
    if_a.rx_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_val("ovr_clr_valid", 32'(if_a.rx_valid),    32'd0);
    check_val("ovr_clr_flag",  32'(if_a.overrun_err), 32'd0);
    check_val("ovr_hold_data", 32'(if_a.rx_data),     32'h11);
    expect_frame(0, "ovr_accept", 9'h011, 1'b0, 1'b0);
    tick_n(1);

    run_frame(0, "stop_low", 9'h055, 1'b0, 2'b10);
    run_frame(1, "stop2_low", 9'h055, 1'b0, 2'b01);

    abort_case(0, 1'b1, "abort_rst");
    abort_case(0, 1'b0, "abort_en");
    abort_case(2, 1'b1, "abort_rst9");
    abort_case(2, 1'b0, "abort_en9");

    for (int k = 0; k < 18; k++) begin
      logic [8:0] rd;
      logic       pf;
      logic [1:0] sp;
      rd = 9'($urandom);
      pf = ($urandom_range(0, 3) == 0);
      sp = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
      run_frame(k % 3, "rand", rd, pf, sp);
      tick_n($urandom_range(0, 20));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
